mem_access: RTL
===============

Name: mem_access

Overview:
- Memory-access stage of the 5-stage pipeline, between the ex_mem pipeline register and mem_wb.
- Executes loads and stores over a req/ack data bus. Other ops pass through combinationally.
- Raises stallreq while a bus transfer is outstanding.
- Produces the final mem_wd/mem_wreg/mem_wdata consumed by mem_wb.
- Big-endian byte lanes: byte 0 is data[31:24].

Parameters:
- ACK_TIMEOUT, 255: maximum cycles spent in WAIT before the access is aborted. 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-high (`RstEnable`)
- mem_wd_i  in  5  destination register address from ex_mem
- mem_wreg_i  in  1  write enable from ex_mem
- mem_wdata_i  in  32  ALU result from ex_mem
- mem_aluop_i  in  8  operation code (`AluOpBus`)
- mem_addr_i  in  32  effective address for load/store
- mem_reg2_i  in  32  store data (rt)
- bus_rdata  in  32  read data, valid when bus_ack=1
- bus_ack  in  1  transfer complete; honoured only while bus_req=1
- mem_wd  out  5  to mem_wb
- mem_wreg  out  1  to mem_wb
- mem_wdata  out  32  to mem_wb
- bus_req  out  1  access request
- bus_we  out  1  1=store
- bus_addr  out  32  word-aligned address {mem_addr_i[31:2],2'b00}
- bus_sel  out  4  byte enables, sel[3] = data[31:24]
- bus_wdata  out  32  store data replicated across lanes
- stallreq  out  1  hold ex_mem and earlier stages
- mem_err  out  1  one-cycle pulse: misaligned access or bus timeout

Behaviour:
- Reset (sync, rst=1):
  - FSM goes to IDLE and the counter clears.
  - Outputs: mem_wd=`NOPRegAddr`, mem_wreg=`WriteDisable`, mem_wdata=`ZeroWord`.
  - bus_req=0, stallreq=0, mem_err=0.
  - A reset during WAIT drops bus_req in the same cycle. Any later ack is ignored.
- Non-memory ops: mem_wd/mem_wreg/mem_wdata follow the inputs combinationally. stallreq=0 and bus_req=0.
- Supported ops: LB, LBU, LH, LHU, LW, SB, SH, SW.
- Misalignment:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - No bus access and no stall. mem_wreg=0, mem_err=1 for that cycle.
- bus_sel:
  - Byte: addr 00→1000, 01→0100, 10→0010, 11→0001.
  - Half: 00→1100, 10→0011.
  - Word: 1111.
- bus_wdata: SB = {4{rt[7:0]}}, SH = {2{rt[15:0]}}, SW = rt.
- FSM states IDLE, WAIT, DONE:
  - IDLE, aligned memory op: bus_req=1, stallreq=1.
    - bus_ack=1 → capture rdata, go to DONE.
    - Otherwise → WAIT, counter=1.
  - WAIT: bus_req=1, stallreq=1, counter increments each cycle.
    - bus_ack=1 → capture bus_rdata into rdata_q, go to DONE.
    - counter==ACK_TIMEOUT (≠0) with no ack → set err_q, go to DONE.
  - DONE: bus_req=0, stallreq=0.
    - Loads: mem_wdata = rdata_q extracted by lane and sign/zero extended.
    - Stores: mem_wreg=0.
    - err_q set: mem_wreg=0 and mem_err=1.
    - Always → IDLE next cycle; the pipeline advances on this edge.
- Latency: a memory op stalls for at least 1 cycle; total cycles = ack wait + 2.
- A simultaneous ack and timeout in the same cycle counts as ack.
- bus_addr, bus_we, bus_sel and bus_wdata hold stable while bus_req=1, because inputs are frozen by the stall.

Decomposition:
- Shared defines:
  - EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP codes.
  - `RstEnable`, `WriteDisable`, `ZeroWord`, `NOPRegAddr`, `AluOpBus`, `RegBus`, `RegAddrBus`.
  - State encodings MEM_IDLE/MEM_WAIT/MEM_DONE.
- One sub-module, mem_load_align: combinational lane extract plus sign/zero extend from (aluop, addr[1:0], rdata).

Test Plan:
- ADDU result 0x0000_1234, wd=5, wreg=1 → same cycle mem_wdata=0x1234, wd=5, wreg=1, stallreq=0, bus_req=0.
- LB addr 0x101, ack after 2 wait cycles with rdata 0x11_80_33_44 → sel=0100; stallreq high 3 cycles; DONE mem_wdata=0xFFFF_FF80; LBU variant gives 0x0000_0080.
- SH addr 0x202, rt=0xAAAA_BEEF, ack same cycle → bus_we=1, sel=0011, wdata=0xBEEF_BEEF, stallreq 1 cycle, DONE mem_wreg=0.
- LW addr 0x103 → no bus_req, no stall, mem_err=1, mem_wreg=0.
- LW with ACK_TIMEOUT=4 and ack never asserted → bus_req drops after 4 WAIT cycles, DONE mem_err=1, mem_wreg=0, IDLE next cycle.
- rst=1 during WAIT, then ack arrives → bus_req=0 next edge, outputs at reset values, ack ignored, FSM in IDLE.

Source files
------------

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared op codes, bus types, FSM states and lane helpers for mem_access
package mem_access_pkg;

  typedef logic [7:0]  alu_op_t;
  typedef logic [31:0] reg_t;
  typedef logic [4:0]  reg_addr_t;

  localparam logic      RST_ENABLE    = 1'b1;
  localparam logic      WRITE_DISABLE = 1'b0;
  localparam reg_t      ZERO_WORD     = 32'h0000_0000;
  localparam reg_addr_t NOP_REG_ADDR  = 5'b00000;

  localparam alu_op_t EXE_LB_OP  = 8'b1110_0000;
  localparam alu_op_t EXE_LH_OP  = 8'b1110_0001;
  localparam alu_op_t EXE_LW_OP  = 8'b1110_0011;
  localparam alu_op_t EXE_LBU_OP = 8'b1110_0100;
  localparam alu_op_t EXE_LHU_OP = 8'b1110_0101;
  localparam alu_op_t EXE_SB_OP  = 8'b1110_1000;
  localparam alu_op_t EXE_SH_OP  = 8'b1110_1001;
  localparam alu_op_t EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  function automatic logic is_load(input alu_op_t op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store(input alu_op_t op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic is_half(input alu_op_t op);
    return (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
  endfunction

  function automatic logic is_word(input alu_op_t op);
    return (op == EXE_LW_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic is_misaligned(input alu_op_t op, input logic [1:0] a);
    return (is_half(op) && a[0]) || (is_word(op) && (a != 2'b00));
  endfunction

  // Big-endian lanes: sel[3] covers data[31:24], which is byte address 0.
  function automatic logic [3:0] bus_sel_for(input alu_op_t op, input logic [1:0] a);
    logic [3:0] sel;
    sel = 4'b0000;
    if (is_word(op)) begin
      sel = 4'b1111;
    end else if (is_half(op)) begin
      sel = a[1] ? 4'b0011 : 4'b1100;
    end else if (is_load(op) || is_store(op)) begin
      sel = 4'b1000 >> a;
    end
    return sel;
  endfunction

  function automatic reg_t bus_wdata_for(input alu_op_t op, input reg_t rt);
    reg_t d;
    case (op)
      EXE_SB_OP: d = {4{rt[7:0]}};
      EXE_SH_OP: d = {2{rt[15:0]}};
      default:   d = rt;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// rtl/mem_access_load_align.sv - extracts the addressed load lane and sign/zero extends it
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [7:0]  aluop_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_i)
      2'b00:   byte_lane = rdata_i[31:24];
      2'b01:   byte_lane = rdata_i[23:16];
      2'b10:   byte_lane = rdata_i[15:8];
      default: byte_lane = rdata_i[7:0];
    endcase
    half_lane = addr_i[1] ? rdata_i[15:0] : rdata_i[31:16];
  end

  always_comb begin
    case (aluop_i)
      EXE_LB_OP:  data_o = {{24{byte_lane[7]}}, byte_lane};
      EXE_LBU_OP: data_o = {24'h000000, byte_lane};
      EXE_LH_OP:  data_o = {{16{half_lane[15]}}, half_lane};
      EXE_LHU_OP: data_o = {16'h0000, half_lane};
      default:    data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - pipeline memory-access stage: load/store over a req/ack bus with stall
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [7:0]  mem_aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_reg2_i,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  output logic        stallreq,
  output logic        mem_err
);

  localparam logic        TIMEOUT_EN  = (ACK_TIMEOUT != 0);
  localparam logic [15:0] TIMEOUT_CNT = 16'(ACK_TIMEOUT);

  mem_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  reg_t        rdata_q, rdata_d;

  logic op_load, op_mem, misaligned;
  reg_t load_data;

  assign op_load    = is_load(mem_aluop_i);
  assign op_mem     = op_load || is_store(mem_aluop_i);
  assign misaligned = is_misaligned(mem_aluop_i, mem_addr_i[1:0]);

  // The stall freezes ex_mem, so these follow the inputs and stay stable during a transfer.
  assign bus_we    = is_store(mem_aluop_i);
  assign bus_addr  = {mem_addr_i[31:2], 2'b00};
  assign bus_sel   = bus_sel_for(mem_aluop_i, mem_addr_i[1:0]);
  assign bus_wdata = bus_wdata_for(mem_aluop_i, mem_reg2_i);

  mem_load_align u_load_align (
    .aluop_i (mem_aluop_i),
    .addr_i  (mem_addr_i[1:0]),
    .rdata_i (rdata_q),
    .data_o  (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= MEM_IDLE;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
      rdata_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    mem_wd    = mem_wd_i;
    mem_wreg  = mem_wreg_i;
    mem_wdata = mem_wdata_i;
    bus_req   = 1'b0;
    stallreq  = 1'b0;
    mem_err   = 1'b0;

    // Outputs are forced while reset is held so an in-flight request drops immediately.
    if (rst == RST_ENABLE) begin
      mem_wd    = NOP_REG_ADDR;
      mem_wreg  = WRITE_DISABLE;
      mem_wdata = ZERO_WORD;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          if (op_mem && misaligned) begin
            mem_wreg = WRITE_DISABLE;
            mem_err  = 1'b1;
          end else if (op_mem) begin
            bus_req  = 1'b1;
            stallreq = 1'b1;
            mem_wreg = WRITE_DISABLE;
            err_d    = 1'b0;
            if (bus_ack) begin
              rdata_d = bus_rdata;
              state_d = MEM_DONE;
            end else begin
              cnt_d   = 16'd1;
              state_d = MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          bus_req  = 1'b1;
          stallreq = 1'b1;
          mem_wreg = WRITE_DISABLE;
          if (bus_ack) begin
            rdata_d = bus_rdata;
            state_d = MEM_DONE;
          end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_CNT)) begin
            err_d   = 1'b1;
            state_d = MEM_DONE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        MEM_DONE: begin
          if (op_load) begin
            mem_wdata = load_data;
          end
          if (!op_load || err_q) begin
            mem_wreg = WRITE_DISABLE;
          end
          mem_err = err_q;
          err_d   = 1'b0;
          state_d = MEM_IDLE;
        end
        default: begin
          state_d = MEM_IDLE;
        end
      endcase
    end
  end

endmodule
